// File: rtl/i2c_sniff_decoder.sv
// Passive I2C bus decoder: conditions the tapped SCL/SDA pins, detects START/STOP,
// assembles bytes and reports device-address, register-address and data bytes with one-cycle strobes.
module i2c_sniff_decoder #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] address,
    output logic       address_ready,
    output logic [7:0] reg_address,
    output logic       reg_address_ready,
    output logic [7:0] reg_data,
    output logic       reg_data_ready,
    output logic       ack,
    output logic       bus_busy,
    output logic       frame_error
);

    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_REG  = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic [3:0] scl_cnt_r;
    logic [3:0] sda_cnt_r;
    logic       scl_f_r;
    logic       sda_f_r;
    logic       scl_d_r;
    logic       sda_d_r;

    logic       scl_rise_s;
    logic       start_s;
    logic       stop_s;
    logic       ev_rise_r;
    logic       ev_start_r;
    logic       ev_stop_r;
    logic       ev_bit_r;

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [3:0] bit_cnt_r;
    logic [6:0] shift_r;
    logic [7:0] byte_s;
    logic       byte_done_s;
    logic       frame_err_s;

    logic       addr_pend_r;
    logic       reg_pend_r;
    logic       data_pend_r;

    logic [7:0] address_r;
    logic       address_ready_r;
    logic [7:0] reg_address_r;
    logic       reg_address_ready_r;
    logic [7:0] reg_data_r;
    logic       reg_data_ready_r;
    logic       ack_r;
    logic       bus_busy_r;
    logic       frame_error_r;

    // Two-flop synchronizers; reset to the idle (high) bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl};
            sda_sync_r <= {sda_sync_r[0], sda};
        end
    end

    // SCL stability filter: level changes only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_cnt_r <= 4'd0;
            scl_f_r   <= 1'b1;
        end else if (scl_sync_r[1] == scl_f_r) begin
            scl_cnt_r <= 4'd0;
        end else if (scl_cnt_r == FILT_LAST) begin
            scl_cnt_r <= 4'd0;
            scl_f_r   <= scl_sync_r[1];
        end else begin
            scl_cnt_r <= scl_cnt_r + 4'd1;
        end
    end

    // SDA stability filter, identical to the SCL one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_cnt_r <= 4'd0;
            sda_f_r   <= 1'b1;
        end else if (sda_sync_r[1] == sda_f_r) begin
            sda_cnt_r <= 4'd0;
        end else if (sda_cnt_r == FILT_LAST) begin
            sda_cnt_r <= 4'd0;
            sda_f_r   <= sda_sync_r[1];
        end else begin
            sda_cnt_r <= sda_cnt_r + 4'd1;
        end
    end

    // Previous filtered levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d_r <= 1'b1;
            sda_d_r <= 1'b1;
        end else begin
            scl_d_r <= scl_f_r;
            sda_d_r <= sda_f_r;
        end
    end

    // Bus conditions; START/STOP need SCL high on both sides, so a simultaneous SCL change wins.
    always_comb begin
        scl_rise_s = scl_f_r & ~scl_d_r;
        start_s    = scl_f_r & scl_d_r & ~sda_f_r & sda_d_r;
        stop_s     = scl_f_r & scl_d_r & sda_f_r & ~sda_d_r;
    end

    // Registered bus events feeding the byte assembler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_rise_r  <= 1'b0;
            ev_start_r <= 1'b0;
            ev_stop_r  <= 1'b0;
            ev_bit_r   <= 1'b1;
        end else begin
            ev_rise_r  <= scl_rise_s;
            ev_start_r <= start_s;
            ev_stop_r  <= stop_s;
            ev_bit_r   <= sda_f_r;
        end
    end

    // Byte completion, framing check and phase transitions.
    // The SCL rise that precedes every START/STOP is itself counted as a bit, so a condition
    // seen with exactly one bit counted sits on a byte boundary; more means a partial byte.
    always_comb begin
        byte_s      = {shift_r, ev_bit_r};
        byte_done_s = ev_rise_r && (state_r != ST_IDLE) && (bit_cnt_r == 4'd7);
        frame_err_s = (ev_start_r || ev_stop_r) && (bit_cnt_r > 4'd1);
        state_nxt_s = state_r;
        if (ev_start_r) begin
            state_nxt_s = ST_ADDR;
        end else if (ev_stop_r) begin
            state_nxt_s = ST_IDLE;
        end else if (byte_done_s) begin
            case (state_r)
                ST_ADDR: state_nxt_s = byte_s[0] ? ST_DATA : ST_REG;
                ST_REG:  state_nxt_s = ST_DATA;
                ST_DATA: state_nxt_s = ST_DATA;
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Phase register, bit counter, shifter, output byte registers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= 4'd0;
            shift_r       <= 7'd0;
            address_r     <= 8'd0;
            reg_address_r <= 8'd0;
            reg_data_r    <= 8'd0;
            addr_pend_r   <= 1'b0;
            reg_pend_r    <= 1'b0;
            data_pend_r   <= 1'b0;
            ack_r         <= 1'b0;
            bus_busy_r    <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            addr_pend_r   <= 1'b0;
            reg_pend_r    <= 1'b0;
            data_pend_r   <= 1'b0;
            frame_error_r <= frame_err_s;

            if (ev_start_r || ev_stop_r) begin
                bit_cnt_r <= 4'd0;
            end else if (ev_rise_r && (state_r != ST_IDLE)) begin
                if (bit_cnt_r == 4'd8) begin
                    ack_r     <= ev_bit_r;
                    bit_cnt_r <= 4'd0;
                end else begin
                    shift_r   <= byte_s[6:0];
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end

            if (byte_done_s) begin
                case (state_r)
                    ST_ADDR: begin
                        address_r   <= byte_s;
                        addr_pend_r <= 1'b1;
                    end
                    ST_REG: begin
                        reg_address_r <= byte_s;
                        reg_pend_r    <= 1'b1;
                    end
                    default: begin
                        reg_data_r  <= byte_s;
                        data_pend_r <= 1'b1;
                    end
                endcase
            end

            if (ev_start_r) begin
                bus_busy_r <= 1'b1;
            end else if (ev_stop_r) begin
                bus_busy_r <= 1'b0;
            end
        end
    end

    // Ready strobes trail the byte register update by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_ready_r     <= 1'b0;
            reg_address_ready_r <= 1'b0;
            reg_data_ready_r    <= 1'b0;
        end else begin
            address_ready_r     <= addr_pend_r;
            reg_address_ready_r <= reg_pend_r;
            reg_data_ready_r    <= data_pend_r;
        end
    end

    assign address           = address_r;
    assign address_ready     = address_ready_r;
    assign reg_address       = reg_address_r;
    assign reg_address_ready = reg_address_ready_r;
    assign reg_data          = reg_data_r;
    assign reg_data_ready    = reg_data_ready_r;
    assign ack               = ack_r;
    assign bus_busy          = bus_busy_r;
    assign frame_error       = frame_error_r;

endmodule
